// File: rtl/tap_controller_if.sv
// Pin-level bundle between the JTAG pins / scan chains and tap_controller.
// The controller uses the slave modport; whatever drives the pins uses master.
interface tap_controller_if;
   logic       TMS;
   logic       TDI;
   logic       BSR_SO;
   logic       SCAN_SO;
   logic       TDO;
   logic       TDO_EN;
   logic [3:0] TAP_STATE;
   logic       CAPTURE_DR;
   logic       SHIFT_DR;
   logic       UPDATE_DR;
   logic       BSR_SEL;
   logic       SCAN_SEL;
   logic       EXTEST_MODE;

   modport slave (
      input  TMS, TDI, BSR_SO, SCAN_SO,
      output TDO, TDO_EN, TAP_STATE, CAPTURE_DR, SHIFT_DR, UPDATE_DR,
             BSR_SEL, SCAN_SEL, EXTEST_MODE
   );

   modport master (
      output TMS, TDI, BSR_SO, SCAN_SO,
      input  TDO, TDO_EN, TAP_STATE, CAPTURE_DR, SHIFT_DR, UPDATE_DR,
             BSR_SEL, SCAN_SEL, EXTEST_MODE
   );
endinterface

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller with instruction register, bypass register and TDO mux.
// Define TAP_IDCODE_EN to add the 32-bit IDCODE register and make IDCODE the reset instruction.
module tap_controller #(
   parameter int unsigned       IR_W       = 4,
   parameter logic [31:0]       IDCODE_VAL = 32'h1000_0A6F,
   parameter logic [IR_W-1:0]   IR_CAPTURE = IR_W'(4'b0101)
) (
   input logic               TCK,
   input logic               TRSTN,
   tap_controller_if.slave   bus
);

   typedef enum logic [3:0] {
      TLR      = 4'hF, RTI      = 4'hC, SEL_DR   = 4'h7, CAP_DR   = 4'h6,
      SH_DR    = 4'h2, EX1_DR   = 4'h1, PAUSE_DR = 4'h3, EX2_DR   = 4'h0,
      UPD_DR   = 4'h5, SEL_IR   = 4'h4, CAP_IR   = 4'hE, SH_IR    = 4'hA,
      EX1_IR   = 4'h9, PAUSE_IR = 4'hB, EX2_IR   = 4'h8, UPD_IR   = 4'hD
   } tap_state_e;

   localparam logic [IR_W-1:0] OP_EXTEST = IR_W'(4'b0000);
   localparam logic [IR_W-1:0] OP_SAMPLE = IR_W'(4'b0001);
   localparam logic [IR_W-1:0] OP_SCANCH = IR_W'(4'b1101);
   localparam logic [IR_W-1:0] OP_BYPASS = {IR_W{1'b1}};
`ifdef TAP_IDCODE_EN
   localparam logic [IR_W-1:0] OP_IDCODE   = IR_W'(4'b0010);
   localparam logic [IR_W-1:0] RESET_INSTR = OP_IDCODE;
`else
   localparam logic [IR_W-1:0] RESET_INSTR = OP_BYPASS;
`endif

   if (IDCODE_VAL[0] != 1'b1 || IR_CAPTURE[1:0] != 2'b01) begin : g_param_check
      $error("tap_controller: IDCODE_VAL[0] must be 1 and IR_CAPTURE[1:0] must be 01");
   end

   tap_state_e      state_q, state_d;
   logic [IR_W-1:0] ir_q, ir_d, ir_sh_q;
   logic            bypass_q, bypass_so, dr_so;
   logic            capture_dr_q, shift_dr_q, update_dr_q;
   logic            bsr_sel_q, scan_sel_q, extest_q;
   logic            tdo_q, tdo_en_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         TLR:      state_d = bus.TMS ? TLR      : RTI;
         RTI:      state_d = bus.TMS ? SEL_DR   : RTI;
         SEL_DR:   state_d = bus.TMS ? SEL_IR   : CAP_DR;
         CAP_DR:   state_d = bus.TMS ? EX1_DR   : SH_DR;
         SH_DR:    state_d = bus.TMS ? EX1_DR   : SH_DR;
         EX1_DR:   state_d = bus.TMS ? UPD_DR   : PAUSE_DR;
         PAUSE_DR: state_d = bus.TMS ? EX2_DR   : PAUSE_DR;
         EX2_DR:   state_d = bus.TMS ? UPD_DR   : SH_DR;
         UPD_DR:   state_d = bus.TMS ? SEL_DR   : RTI;
         SEL_IR:   state_d = bus.TMS ? TLR      : CAP_IR;
         CAP_IR:   state_d = bus.TMS ? EX1_IR   : SH_IR;
         SH_IR:    state_d = bus.TMS ? EX1_IR   : SH_IR;
         EX1_IR:   state_d = bus.TMS ? UPD_IR   : PAUSE_IR;
         PAUSE_IR: state_d = bus.TMS ? EX2_IR   : PAUSE_IR;
         EX2_IR:   state_d = bus.TMS ? UPD_IR   : SH_IR;
         UPD_IR:   state_d = bus.TMS ? SEL_DR   : RTI;
         default:  state_d = TLR;
      endcase
   end

   // The IR is only ever written when leaving Update-IR or on entry to TLR.
   always_comb begin
      ir_d = ir_q;
      if (state_d == TLR)
         ir_d = RESET_INSTR;
      else if (state_q == UPD_IR)
         ir_d = ir_sh_q;
   end

   // Strobes and selects are registered from next-state/next-IR so they line up with TAP_STATE.
   always_ff @(posedge TCK or negedge TRSTN) begin
      if (!TRSTN) begin
         state_q      <= TLR;
         ir_q         <= RESET_INSTR;
         ir_sh_q      <= IR_CAPTURE;
         bypass_q     <= 1'b0;
         capture_dr_q <= 1'b0;
         shift_dr_q   <= 1'b0;
         update_dr_q  <= 1'b0;
         bsr_sel_q    <= 1'b0;
         scan_sel_q   <= 1'b0;
         extest_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         ir_q         <= ir_d;
         capture_dr_q <= (state_d == CAP_DR);
         shift_dr_q   <= (state_d == SH_DR);
         update_dr_q  <= (state_d == UPD_DR);
         bsr_sel_q    <= (ir_d == OP_EXTEST) || (ir_d == OP_SAMPLE);
         scan_sel_q   <= (ir_d == OP_SCANCH);
         extest_q     <= (ir_d == OP_EXTEST);
         case (state_q)
            CAP_IR:  ir_sh_q <= IR_CAPTURE;
            SH_IR:   ir_sh_q <= {bus.TDI, ir_sh_q[IR_W-1:1]};
            default: ;
         endcase
         if (state_q == CAP_DR)
            bypass_q <= 1'b0;
         else if (state_q == SH_DR)
            bypass_q <= bus.TDI;
      end
   end

`ifdef TAP_IDCODE_EN
   logic [31:0] idcode_q;

   always_ff @(posedge TCK or negedge TRSTN) begin
      if (!TRSTN)
         idcode_q <= IDCODE_VAL;
      else if (state_q == CAP_DR)
         idcode_q <= IDCODE_VAL;
      else if (state_q == SH_DR)
         idcode_q <= {bus.TDI, idcode_q[31:1]};
   end

   assign bypass_so = (ir_q == OP_IDCODE) ? idcode_q[0] : bypass_q;
`else
   assign bypass_so = bypass_q;
`endif

   always_comb begin
      dr_so = bypass_so;
      if (bsr_sel_q)
         dr_so = bus.BSR_SO;
      else if (scan_sel_q)
         dr_so = bus.SCAN_SO;
   end

   // TDO changes on the falling edge so the far end can sample it on the next rising edge.
   always_ff @(negedge TCK or negedge TRSTN) begin
      if (!TRSTN) begin
         tdo_q    <= 1'b0;
         tdo_en_q <= 1'b0;
      end else if (state_q == SH_IR) begin
         tdo_q    <= ir_sh_q[0];
         tdo_en_q <= 1'b1;
      end else if (state_q == SH_DR) begin
         tdo_q    <= dr_so;
         tdo_en_q <= 1'b1;
      end else begin
         tdo_en_q <= 1'b0;
      end
   end

   assign bus.TDO         = tdo_q;
   assign bus.TDO_EN      = tdo_en_q;
   assign bus.TAP_STATE   = state_q;
   assign bus.CAPTURE_DR  = capture_dr_q;
   assign bus.SHIFT_DR    = shift_dr_q;
   assign bus.UPDATE_DR   = update_dr_q;
   assign bus.BSR_SEL     = bsr_sel_q;
   assign bus.SCAN_SEL    = scan_sel_q;
   assign bus.EXTEST_MODE = extest_q;

endmodule

// File: doc/tap_controller.md
Name: tap_controller

Overview:
- IEEE 1149.1 TAP controller and instruction register for the GCD boundary-scan top level.
- Sits directly downstream of the TCK/TMS/TDI/TRSTN pins. Decodes the 4-bit instruction and generates the capture, shift and update strobes for the boundary-scan register (BSR), the internal scan chain (SCANCH) and the bypass register.
- Owns the TDO output mux. The instruction register (IR), bypass register and optional IDCODE register are internal to this block.

Parameters:
- IR_W, 4, instruction register width.
- IDCODE_VAL, 32'h1000_0A6F, device ID value; bit 0 must be 1.
- IR_CAPTURE, 4'b0101, value loaded into the IR shifter in Capture-IR; bits [1:0] must be 01.

Ports:
- TCK  in  1  test clock; the only clock.
- TRSTN  in  1  asynchronous active-low reset.
- TMS  in  1  mode select, sampled on rising TCK.
- TDI  in  1  serial data in, sampled on rising TCK.
- BSR_SO  in  1  serial out of the boundary-scan register.
- SCAN_SO  in  1  serial out of the internal scan chain.
- TDO  out  1  serial data out, updated on falling TCK.
- TDO_EN  out  1  high while TDO is valid.
- TAP_STATE  out  4  current FSM state, for debug and verification.
- CAPTURE_DR  out  1  one-cycle strobe while in Capture-DR.
- SHIFT_DR  out  1  high while in Shift-DR.
- UPDATE_DR  out  1  one-cycle strobe while in Update-DR.
- BSR_SEL  out  1  current instruction targets the BSR (EXTEST or SAMPLE).
- SCAN_SEL  out  1  current instruction is SCANCH.
- EXTEST_MODE  out  1  BSR drives the pins (EXTEST active).

Behaviour:
- Clocking and reset: single clock TCK, asynchronous active-low reset TRSTN.
- All state registers update on rising TCK. TDO and TDO_EN are registered on falling TCK.
- TRSTN=0 forces the following immediately, at any time including mid-shift:
  - FSM to Test-Logic-Reset (TLR).
  - IR to the reset instruction; IR shifter to IR_CAPTURE.
  - Bypass register to 0.
  - TDO=0, TDO_EN=0.
  - All strobes and select outputs to 0.
- FSM: 16 states with standard 1149.1 transitions on TMS.
  - Encoding: TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D.
  - TMS=1 for 5 consecutive rising edges reaches TLR from any state.
  - Entering TLR loads the reset instruction into the IR.
- IR behaviour:
  - CapIR: shifter <= IR_CAPTURE.
  - ShIR: shifter <= {TDI, shifter[IR_W-1:1]}, LSB out first.
  - UpdIR: IR <= shifter.
  - The IR changes only in UpdIR or TLR.
- Opcodes:
  - EXTEST=0000: BSR_SEL=1, EXTEST_MODE=1.
  - SAMPLE=0001: BSR_SEL=1.
  - IDCODE=0010.
  - SCANCH=1101: SCAN_SEL=1.
  - BYPASS=1111.
  - Any other code decodes as BYPASS.
- Data registers:
  - Bypass: CapDR loads 0; ShDR loads TDI. One-bit TDI-to-TDO path.
  - IDCODE: CapDR loads IDCODE_VAL; ShDR shifts right with TDI entering the MSB.
- Strobes: CAPTURE_DR, SHIFT_DR and UPDATE_DR are decoded from the current state, independent of the instruction.
  - The selected external register qualifies them with BSR_SEL or SCAN_SEL.
- TDO mux, sampled on falling TCK:
  - ShIR: shifter[0].
  - ShDR: selected DR serial out (BSR_SO, SCAN_SO, IDCODE[0] or bypass).
  - Otherwise: TDO_EN=0 and TDO holds its last value.
  - TDO_EN=1 only during ShIR or ShDR.
- Pause states hold all shifters unchanged.
- Exit1 states perform no shift; the last shift happens on the edge that leaves ShIR or ShDR.

Optional Feature:
- Macro: TAP_IDCODE_EN.
- Defined:
  - The 32-bit IDCODE register exists.
  - Reset instruction is IDCODE, so the first DR scan after reset returns IDCODE_VAL LSB first.
- Undefined:
  - No IDCODE register.
  - Opcode 0010 decodes as BYPASS.
  - Reset instruction is BYPASS, so the first DR scan after reset returns a leading 0 followed by delayed TDI.

Test Plan:
- Reset: TRSTN=0 for 5 TCK, then release -> TAP_STATE=F; IR=0010 (IDCODE_EN) or 1111; TDO_EN=0; all selects 0.
- TMS-1 escape: from ShDR, mid-shift, apply TMS=1 for 5 TCK -> TAP_STATE=F and IR reset to the default instruction.
- SCANCH load: TMS 1,1,0,0, then TDI 1,0,1,1 with TMS=1 on the last bit, then TMS=1 -> after UpdIR SCAN_SEL=1 and BSR_SEL=0. TDO during ShIR reads 1,0,1,0 (capture 0101, LSB first).
- SCANCH flush: with SCANCH loaded, enter ShDR and shift 11001 -> SHIFT_DR=1 for 5 cycles; TDO mirrors SCAN_SO delayed half a TCK. UPDATE_DR pulses once.
- Bypass: load 1111, shift DR with TDI=1,0,1,1 -> TDO=0,1,0,1, a one-bit delay with a leading captured 0.
- IDCODE and async reset: with IDCODE_EN, reset, then shift DR for 32 bits -> TDO = IDCODE_VAL LSB first. Assert TRSTN at bit 10 -> TAP_STATE=F immediately (before the next edge) and TDO_EN=0.
